// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with ARM-style NZCV status register and ALU carry feedback.
// Optional EXE_FLAG_CNT_EN adds flag_upd_cnt, a wrapping count of status-register writes.
module exe_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [3:0]  ALU_Comnd,
    input  logic [31:0] Val1,
    input  logic [31:0] Val2,
    input  logic [31:0] ALU_out,
    input  logic        S,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [3:0]  Dest_in,
    input  logic [31:0] Val_Rm_in,
    output logic [31:0] ALU_Res,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic [3:0]  Dest,
    output logic [31:0] Val_Rm,
    output logic        valid_out,
    output logic [3:0]  status,
`ifdef EXE_FLAG_CNT_EN
    output logic [15:0] flag_upd_cnt,
`endif
    output logic        C_to_alu
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cin;
    logic [3:0] status_next;

    assign C_to_alu = status[1];

    always_comb begin
        flag_n = ALU_out[31];
        flag_z = (ALU_out == '0);
        flag_c = status[1];
        flag_v = status[0];
        cin    = 1'b0;
        case (ALU_Comnd)
            CMD_ADD, CMD_ADC: begin
                cin    = (ALU_Comnd == CMD_ADC) ? status[1] : 1'b0;
                flag_c = 1'(({1'b0, Val1} + {1'b0, Val2} + 33'(cin)) >> 32);
                flag_v = (Val1[31] == Val2[31]) & (ALU_out[31] != Val1[31]);
            end
            CMD_SUB, CMD_SBC: begin
                cin    = (ALU_Comnd == CMD_SBC) ? ~status[1] : 1'b0;
                // carry out of a subtract is the inverted borrow
                flag_c = ~1'(({1'b0, Val1} - {1'b0, Val2} - 33'(cin)) >> 32);
                flag_v = (Val1[31] != Val2[31]) & (ALU_out[31] != Val1[31]);
            end
            default: ;
        endcase
        status_next = {flag_n, flag_z, flag_c, flag_v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Res   <= '0;
            WB_EN     <= 1'b0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
            Dest      <= '0;
            Val_Rm    <= '0;
            valid_out <= 1'b0;
            status    <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
            WB_EN     <= 1'b0;
            MEM_R_EN  <= 1'b0;
            MEM_W_EN  <= 1'b0;
        end else if (!freeze) begin
            ALU_Res   <= ALU_out;
            Dest      <= Dest_in;
            Val_Rm    <= Val_Rm_in;
            valid_out <= valid_in;
            WB_EN     <= WB_EN_in & valid_in;
            MEM_R_EN  <= MEM_R_EN_in & valid_in;
            MEM_W_EN  <= MEM_W_EN_in & valid_in;
            if (S & valid_in)
                status <= status_next;
        end
    end

`ifdef EXE_FLAG_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            flag_upd_cnt <= '0;
        else if (!flush && !freeze && S && valid_in)
            flag_upd_cnt <= flag_upd_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/exe_mem_reg.md
# exe_mem_reg

- Pipeline stage directly downstream of the ALU.
- Each cycle it:
  - registers the ALU result and the memory/write-back controls into the MEM stage;
  - computes the ARM-style NZCV flags from the ALU command, operands and result;
  - holds them in the status register.
- The registered C flag is fed back to the ALU carry input for ADC/SBC.
- Supports pipeline freeze (stall) and flush (squash).

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold all registers this cycle
- flush  in  1  squash the instruction presented this cycle
- valid_in  in  1  EXE instruction is valid
- ALU_Comnd  in  4  ALU command (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000)
- Val1, Val2  in  32  ALU operands (same values the ALU sees)
- ALU_out  in  32  ALU result
- S  in  1  update status flags
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits
- Dest_in  in  4  destination register
- Val_Rm_in  in  32  store data
- ALU_Res  out  32  registered result
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered controls
- Dest  out  4  registered destination
- Val_Rm  out  32  registered store data
- valid_out  out  1  MEM-stage valid
- status  out  4  {N,Z,C,V}, registered
- C_to_alu  out  1  equals status[1]

## Operation
Flag next-state logic (combinational):
- N = ALU_out[31].
- Z = (ALU_out == 0).
- Carry-in cin = C for ADC, ~C for SBC, 0 otherwise.
- ADD/ADC:
  - sum33 = {1'b0,Val1} + {1'b0,Val2} + cin; C = sum33[32].
  - V = (Val1[31]==Val2[31]) & (ALU_out[31]!=Val1[31]).
- SUB/SBC:
  - dif33 = {1'b0,Val1} - {1'b0,Val2} - cin; C = ~dif33[32] (not-borrow).
  - V = (Val1[31]!=Val2[31]) & (ALU_out[31]!=Val1[31]).
- MOV/MVN/AND/ORR/EOR and undefined codes: C and V keep their old values; N and Z are updated.

Update rule, evaluated at each rising edge in priority order:
- rst: all outputs 0, including status = 4'b0000 and valid_out = 0.
- flush: valid_out, WB_EN, MEM_R_EN and MEM_W_EN become 0; data registers and status keep their values. Flush wins over freeze.
- freeze: every register holds.
- Otherwise:
  - All pipeline registers load their inputs.
  - valid_out = valid_in.
  - Control outputs are loaded ANDed with valid_in.
  - status loads the next-state flags only if S & valid_in; otherwise it holds.

## Timing
- Pipeline latency is one cycle: inputs at edge k appear on outputs after edge k.
- Status write takes effect at the same edge. C_to_alu for the following instruction reflects it: back-to-back ADC chains work without a bubble.
- No combinational path from any input to any output, so no ALU/flag loop.
- Reset mid-stream drops the in-flight instruction and clears flags. The first instruction after reset sees C = 0.
- Simultaneous flush and freeze: flush applies.
- Simultaneous S = 1 and valid_in = 0: status holds.

## Configuration
- Macro: EXE_FLAG_CNT_EN.
- Defined:
  - Adds output flag_upd_cnt [15:0], reset to 0.
  - Increments by 1 on every edge where status is written.
  - Wraps 16'hFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles with non-zero inputs -> every output 0, status = 0000.
- ADD, S = 1, Val1 = 32'hFFFF_FFFF, Val2 = 1, ALU_out = 0 -> next cycle ALU_Res = 0, status = 0110 (Z, C).
- SUB, S = 1, Val1 = 32'h8000_0000, Val2 = 1, ALU_out = 32'h7FFF_FFFF -> status = 0011 (C, V). Follow with SBC, Val1 = 5, Val2 = 2, C = 1, ALU_out = 3 -> status = 0010.
- MOV, S = 1, ALU_out = 32'h8000_0000, previous C = 1, V = 1 -> status = 1011.
- Freeze for 3 cycles while inputs change -> outputs and status unchanged. Assert flush with freeze and S = 1 -> valid_out = 0, controls 0, status unchanged.
- With EXE_FLAG_CNT_EN: 3 S-writes, 1 S with valid_in = 0, 1 flushed S -> flag_upd_cnt = 3.
